// File: rtl/uart_frame_pkg.sv
// Shared types and checksum helpers for the UART frame transmitter.
// Build option UART_FRAME_CRC8_EN switches the trailing check byte from a mod-256 sum to CRC-8.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_RDY,
    FIN
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY         = 8'h07;

  // MSB-first CRC-8, no reflection, processes one whole byte per call
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] check_update(input logic [7:0] acc, input logic [7:0] data);
`ifdef UART_FRAME_CRC8_EN
    return crc8_byte(acc, data);
`else
    return acc + data;
`endif
  endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Framed-packet producer for the UART write side: SYNC, CMD, LEN, payload (byte 0 first), check byte.
// The check byte is a mod-256 sum, or CRC-8 when UART_FRAME_CRC8_EN is defined.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 cmd,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       busy,
  output logic                       done,
  output logic                       uart_wr,
  output logic [7:0]                 uart_data,
  input  logic                       uart_rts
);

  localparam logic [3:0] LAST_IDX  = 4'(PAYLOAD_BYTES + 3);
  localparam logic [7:0] LEN_BYTE  = 8'(PAYLOAD_BYTES);

  state_t                     state_reg, state_next;
  logic [3:0]                 idx_reg, idx_next;
  logic [7:0]                 acc_reg, acc_next;
  logic [7:0]                 cmd_reg, cmd_next;
  logic [8*PAYLOAD_BYTES-1:0] payload_reg, payload_next;
  logic [7:0]                 cur_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      acc_reg     <= '0;
      cmd_reg     <= '0;
      payload_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      acc_reg     <= acc_next;
      cmd_reg     <= cmd_next;
      payload_reg <= payload_next;
    end
  end

  // Payload is held in a shift register, so the current payload byte is always its low byte
  always_comb begin
    cur_byte = payload_reg[7:0];
    if (idx_reg == 4'd0)          cur_byte = SYNC_BYTE;
    else if (idx_reg == 4'd1)     cur_byte = cmd_reg;
    else if (idx_reg == 4'd2)     cur_byte = LEN_BYTE;
    else if (idx_reg == LAST_IDX) cur_byte = acc_reg;
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    acc_next     = acc_reg;
    cmd_next     = cmd_reg;
    payload_next = payload_reg;
    uart_wr      = 1'b0;
    uart_data    = 8'h00;
    done         = 1'b0;
    busy         = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (start) begin
          cmd_next     = cmd;
          payload_next = payload;
          idx_next     = '0;
          acc_next     = '0;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (uart_rts) begin
          uart_wr   = 1'b1;
          uart_data = cur_byte;
          // SYNC and the check byte itself are not folded into the accumulator
          if (idx_reg != 4'd0 && idx_reg != LAST_IDX)
            acc_next = check_update(acc_reg, cur_byte);
          if (idx_reg >= 4'd3 && idx_reg != LAST_IDX)
            payload_next = payload_reg >> 8;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!uart_rts) state_next = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (uart_rts) begin
          if (idx_reg == LAST_IDX) begin
            state_next = FIN;
          end else begin
            idx_next   = idx_reg + 4'd1;
            state_next = ISSUE;
          end
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
